// File: rtl/pencere_olusturucu_if.sv
// Pixel stream in / 3x3 window stream out bundle for pencere_olusturucu.
// master drives etkin_i/pixel_i/stal_i; slave returns etkin_o/resim_o/son_o.
interface pencere_olusturucu_if #(
    parameter int PIXEL_BIT = 8
);
    logic                   etkin_i;
    logic [PIXEL_BIT-1:0]   pixel_i;
    logic                   stal_i;
    logic                   etkin_o;
    logic [9*PIXEL_BIT-1:0] resim_o;
    logic                   son_o;

    modport master (
        output etkin_i, pixel_i, stal_i,
        input  etkin_o, resim_o, son_o
    );

    modport slave (
        input  etkin_i, pixel_i, stal_i,
        output etkin_o, resim_o, son_o
    );
endinterface

// File: rtl/pencere_olusturucu.sv
// Streaming 3x3 window generator feeding the median stage.
// Ports: clk_i, rst_i (async, active-high), bag (slave: pixel in, window out).
module pencere_olusturucu #(
    parameter int RESIM_GEN = 320,
    parameter int RESIM_YUK = 240,
    parameter int PIXEL_BIT = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    pencere_olusturucu_if.slave bag
);
    localparam int SW = $clog2(RESIM_GEN);
    localparam int RW = $clog2(RESIM_YUK);
    localparam logic [SW-1:0] SON_SUTUN = SW'(RESIM_GEN - 1);
    localparam logic [RW-1:0] SON_SATIR = RW'(RESIM_YUK - 1);
    localparam logic [SW-1:0] IKI_S = SW'(2);
    localparam logic [RW-1:0] IKI_R = RW'(2);

    logic [SW-1:0] sutun;
    logic [RW-1:0] satir;

    logic [PIXEL_BIT-1:0] lb_ust  [RESIM_GEN];
    logic [PIXEL_BIT-1:0] lb_orta [RESIM_GEN];

    logic [PIXEL_BIT-1:0] pencere   [3][3];
    logic [PIXEL_BIT-1:0] pencere_n [3][3];

    logic                   kabul;
    logic                   gecerli;
    logic                   son_konum;
    logic [PIXEL_BIT-1:0]   ust_c;
    logic [PIXEL_BIT-1:0]   orta_c;
    logic [9*PIXEL_BIT-1:0] paket;

    logic                   etkin_q;
    logic                   son_q;
    logic [9*PIXEL_BIT-1:0] resim_q;

    assign kabul  = bag.etkin_i && !bag.stal_i;
    assign ust_c  = lb_ust[sutun];
    assign orta_c = lb_orta[sutun];

    // Columns 0/1 still hold the previous row's tail in the window,
    // and rows 0/1 see stale line buffers, so neither may emit.
    assign gecerli   = kabul && (satir >= IKI_R) && (sutun >= IKI_S);
    assign son_konum = (satir == SON_SATIR) && (sutun == SON_SUTUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sutun <= '0;
            satir <= '0;
        end else if (kabul) begin
            if (sutun == SON_SUTUN) begin
                sutun <= '0;
                if (satir == SON_SATIR) begin
                    satir <= '0;
                end else begin
                    satir <= satir + 1'b1;
                end
            end else begin
                sutun <= sutun + 1'b1;
            end
        end
    end

    // Line buffers are plain storage; no reset so they map to RAM.
    always_ff @(posedge clk_i) begin
        if (kabul) begin
            lb_ust[sutun]  <= orta_c;
            lb_orta[sutun] <= bag.pixel_i;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            pencere_n[r][0] = pencere[r][1];
            pencere_n[r][1] = pencere[r][2];
        end
        pencere_n[0][2] = ust_c;
        pencere_n[1][2] = orta_c;
        pencere_n[2][2] = bag.pixel_i;
    end

    always_comb begin
        paket = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                paket[PIXEL_BIT*(3*r+c) +: PIXEL_BIT] = pencere_n[r][c];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    pencere[r][c] <= '0;
                end
            end
        end else if (kabul) begin
            pencere <= pencere_n;
        end
    end

    // resim_o only moves on a qualifying window so it keeps the
    // last valid neighbourhood between emissions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            etkin_q <= 1'b0;
            son_q   <= 1'b0;
            resim_q <= '0;
        end else if (!bag.stal_i) begin
            etkin_q <= gecerli;
            son_q   <= gecerli && son_konum;
            if (gecerli) begin
                resim_q <= paket;
            end
        end
    end

    assign bag.etkin_o = etkin_q;
    assign bag.son_o   = son_q;
    assign bag.resim_o = resim_q;
endmodule

// File: tb/tb_pencere_olusturucu.sv
// Bench for pencere_olusturucu: 4x4 and 5x3 instances vs an image model.
// Directed test-plan steps plus randomized gaps, stalls and pixels.
module tb_pencere_olusturucu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pencere_olusturucu_if #(.PIXEL_BIT(8)) a_if ();
    pencere_olusturucu_if #(.PIXEL_BIT(8)) b_if ();

    pencere_olusturucu #(
        .RESIM_GEN(4), .RESIM_YUK(4), .PIXEL_BIT(8)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .bag(a_if.slave)
    );

    pencere_olusturucu #(
        .RESIM_GEN(5), .RESIM_YUK(3), .PIXEL_BIT(8)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .bag(b_if.slave)
    );

    int checks = 0;
    int errors = 0;

    int gen [2] = '{4, 5};
    int yuk [2] = '{4, 3};

    // Reference model: image as 2D array, window cut out by position.
    int          mr  [2];
    int          mc  [2];
    logic [7:0]  img [2][8][8];
    logic        me  [2];
    logic        ms  [2];
    logic [71:0] mw  [2];

    // Observations taken from the DUT for directed checks.
    int          dut_win [2];
    logic [71:0] ilk_w   [2];
    logic [71:0] son_w   [2];

    task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_adim(int k, logic e, logic [7:0] p,
                                       logic s);
        logic [71:0] w;
        if (rst) begin
            mr[k] = 0; mc[k] = 0;
            me[k] = 1'b0; ms[k] = 1'b0; mw[k] = '0;
            return;
        end
        if (s) return;
        if (!e) begin
            me[k] = 1'b0; ms[k] = 1'b0;
            return;
        end
        img[k][mr[k]][mc[k]] = p;
        if (mr[k] >= 2 && mc[k] >= 2) begin
            w = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[8*(3*i+j) +: 8] = img[k][mr[k]-2+i][mc[k]-2+j];
            me[k] = 1'b1;
            ms[k] = (mr[k] == yuk[k]-1) && (mc[k] == gen[k]-1);
            mw[k] = w;
        end else begin
            me[k] = 1'b0; ms[k] = 1'b0;
        end
        mc[k]++;
        if (mc[k] == gen[k]) begin
            mc[k] = 0;
            mr[k]++;
            if (mr[k] == yuk[k]) mr[k] = 0;
        end
    endfunction

    task automatic kontrol(int k, logic s);
        logic        oe, os;
        logic [71:0] ow;
        if (k == 0) begin
            oe = a_if.etkin_o; os = a_if.son_o; ow = a_if.resim_o;
        end else begin
            oe = b_if.etkin_o; os = b_if.son_o; ow = b_if.resim_o;
        end
        chk(k == 0 ? "a_etkin" : "b_etkin", 72'(oe), 72'(me[k]));
        chk(k == 0 ? "a_son" : "b_son", 72'(os), 72'(ms[k]));
        chk(k == 0 ? "a_resim" : "b_resim", ow, mw[k]);
        if (oe && !s && !rst) begin
            dut_win[k]++;
            if (dut_win[k] == 1) ilk_w[k] = ow;
            son_w[k] = ow;
        end
    endtask

    task automatic adim(int k, logic e, logic [7:0] p, logic s);
        a_if.etkin_i = (k == 0) ? e : 1'b0;
        a_if.stal_i  = (k == 0) ? s : 1'b0;
        a_if.pixel_i = p;
        b_if.etkin_i = (k == 1) ? e : 1'b0;
        b_if.stal_i  = (k == 1) ? s : 1'b0;
        b_if.pixel_i = p;
        @(posedge clk);
        model_adim(0, (k == 0) ? e : 1'b0, p, (k == 0) ? s : 1'b0);
        model_adim(1, (k == 1) ? e : 1'b0, p, (k == 1) ? s : 1'b0);
        #1;
        kontrol(0, (k == 0) ? s : 1'b0);
        kontrol(1, (k == 1) ? s : 1'b0);
    endtask

    function automatic logic [7:0] piks(int k, int base, int idx);
        return 8'(base + idx + 1);
    endfunction

    task automatic kare(int k, int base);
        for (int i = 0; i < gen[k]*yuk[k]; i++)
            adim(k, 1'b1, piks(k, base, i), 1'b0);
    endtask

    task automatic sayac_sifirla();
        dut_win[0] = 0; dut_win[1] = 0;
        ilk_w[0] = '0; ilk_w[1] = '0;
        son_w[0] = '0; son_w[1] = '0;
    endtask

    task automatic rastgele(int k, int kareler);
        int hedef, kabul, tur;
        logic e, s;
        hedef = kareler * gen[k] * yuk[k];
        kabul = 0;
        tur = 0;
        sayac_sifirla();
        while (kabul < hedef && tur < 4000) begin
            e = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < 2);
            adim(k, e, 8'($urandom), s);
            if (e && !s) kabul++;
            tur++;
        end
        adim(k, 1'b0, 8'h00, 1'b0);
        chk("rnd_kabul", 72'(kabul), 72'(hedef));
        chk("rnd_pencere", 72'(dut_win[k]),
            72'(kareler * (gen[k]-2) * (yuk[k]-2)));
    endtask

    initial begin
        int idx, tur;
        logic e, durdu;
        a_if.etkin_i = 1'b0; a_if.stal_i = 1'b0; a_if.pixel_i = '0;
        b_if.etkin_i = 1'b0; b_if.stal_i = 1'b0; b_if.pixel_i = '0;
        for (int k = 0; k < 2; k++) begin
            mr[k] = 0; mc[k] = 0; me[k] = 0; ms[k] = 0; mw[k] = '0;
        end
        sayac_sifirla();

        // Reset state
        #1;
        chk("rst_etkin", 72'(a_if.etkin_o), 72'(0));
        chk("rst_resim", a_if.resim_o, 72'h0);
        adim(0, 1'b0, 8'h00, 1'b0);
        adim(0, 1'b1, 8'h55, 1'b0);
        rst = 1'b0;
        adim(0, 1'b0, 8'h00, 1'b0);

        // Test 1: continuous 4x4 ramp
        sayac_sifirla();
        kare(0, 0);
        adim(0, 1'b0, 8'h00, 1'b0);
        chk("t1_adet", 72'(dut_win[0]), 72'(4));
        chk("t1_ilk", ilk_w[0], 72'h0B0A09070605030201);
        chk("t1_son", son_w[0], 72'h100F0E0C0B0A080706);

        // Test 2: same image, 50% etkin_i gaps
        sayac_sifirla();
        idx = 0; tur = 0;
        while (idx < 16 && tur < 500) begin
            e = 1'($urandom_range(0, 1));
            adim(0, e, piks(0, 0, idx), 1'b0);
            if (e) idx++;
            tur++;
        end
        adim(0, 1'b0, 8'h00, 1'b0);
        chk("t2_kabul", 72'(idx), 72'(16));
        chk("t2_adet", 72'(dut_win[0]), 72'(4));
        chk("t2_ilk", ilk_w[0], 72'h0B0A09070605030201);
        chk("t2_son", son_w[0], 72'h100F0E0C0B0A080706);

        // Test 3: 5-cycle stall right after the second window
        sayac_sifirla();
        durdu = 1'b0;
        for (int i = 0; i < 16; i++) begin
            adim(0, 1'b1, piks(0, 0, i), 1'b0);
            if (!durdu && dut_win[0] == 2) begin
                durdu = 1'b1;
                repeat (5) adim(0, 1'b1, 8'hEE, 1'b1);
            end
        end
        adim(0, 1'b0, 8'h00, 1'b0);
        chk("t3_durdu", 72'(durdu), 72'(1));
        chk("t3_adet", 72'(dut_win[0]), 72'(4));
        chk("t3_son", son_w[0], 72'h100F0E0C0B0A080706);

        // Test 4: back-to-back frames, second offset by 100
        kare(0, 0);
        sayac_sifirla();
        kare(0, 100);
        adim(0, 1'b0, 8'h00, 1'b0);
        chk("t4_adet", 72'(dut_win[0]), 72'(4));
        chk("t4_ilk", ilk_w[0], 72'h6F6E6D6B6A69676665);

        // Test 5: async reset after 9 pixels
        for (int i = 0; i < 9; i++)
            adim(0, 1'b1, piks(0, 0, i), 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_etkin", 72'(a_if.etkin_o), 72'(0));
        chk("t5_resim", a_if.resim_o, 72'h0);
        adim(0, 1'b1, 8'h77, 1'b0);
        adim(0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        sayac_sifirla();
        kare(0, 0);
        adim(0, 1'b0, 8'h00, 1'b0);
        chk("t5_adet", 72'(dut_win[0]), 72'(4));
        chk("t5_ilk", ilk_w[0], 72'h0B0A09070605030201);
        chk("t5_son", son_w[0], 72'h100F0E0C0B0A080706);

        // Test 6: 5x3 ramp
        sayac_sifirla();
        kare(1, 0);
        adim(1, 1'b0, 8'h00, 1'b0);
        chk("t6_adet", 72'(dut_win[1]), 72'(3));
        chk("t6_ilk", ilk_w[1], 72'h0D0C0B080706030201);
        chk("t6_son", son_w[1], 72'h0F0E0D0A0908050403);

        // Randomized pixels, gaps and stalls on both shapes
        rastgele(0, 3);
        rastgele(1, 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
